// File: rtl/ps2_keycode_rx.sv
// PS/2 set-2 keyboard receiver: frames bytes off the raw pins and keeps up to two
// held keys as HID usage codes packed into {slot1, slot0}.
module ps2_keycode_rx #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        PS2_CLK,
    input  logic        PS2_DAT,
    output logic [15:0] keycode,
    output logic        key_event,
    output logic        frame_err
);
    localparam int            CW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;

    logic [2:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          fe;
    logic          bit_in;
    frame_state_t  state;
    logic [7:0]    shift;
    logic [2:0]    bit_cnt;
    logic [CW-1:0] to_cnt;
    logic          parity_ok;
    logic          byte_valid;
    logic          ext;
    logic          brk;
    logic [7:0]    hid;
    logic [7:0]    next0;
    logic [7:0]    next1;

    // NOTE: synchronizers reset to the line idle level (1) so leaving reset never fakes a falling edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            clk_sync <= '1;
            dat_sync <= '1;
        end else begin
            clk_sync <= {clk_sync[1:0], PS2_CLK};
            dat_sync <= {dat_sync[0], PS2_DAT};
        end
    end

    assign fe     = clk_sync[2] & ~clk_sync[1];
    assign bit_in = dat_sync[1];

    // Frame FSM plus inactivity watchdog; a falling edge always beats a timeout in the same cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            shift      <= '0;
            bit_cnt    <= '0;
            to_cnt     <= '0;
            parity_ok  <= 1'b0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (state == IDLE || fe) begin
                to_cnt <= '0;
            end else if (to_cnt == TO_LAST) begin
                to_cnt    <= '0;
                state     <= IDLE;
                frame_err <= 1'b1;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (fe) begin
                unique case (state)
                    IDLE: begin
                        if (!bit_in) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shift   <= {bit_in, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        parity_ok <= ^{shift, bit_in};
                        state     <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (parity_ok && bit_in) byte_valid <= 1'b1;
                        else                     frame_err  <= 1'b1;
                    end
                endcase
            end
        end
    end

    function automatic logic [7:0] to_hid(input logic e, input logic [7:0] code);
        case ({e, code})
            9'h05A:  return 8'h28;
            9'h076:  return 8'h29;
            9'h029:  return 8'h2C;
            9'h04D:  return 8'h13;
            9'h01D:  return 8'h1A;
            9'h01C:  return 8'h04;
            9'h01B:  return 8'h16;
            9'h023:  return 8'h07;
            9'h175:  return 8'h52;
            9'h172:  return 8'h51;
            9'h16B:  return 8'h50;
            9'h174:  return 8'h4F;
            default: return 8'h00;
        endcase
    endfunction

    // NOTE: every always_comb output gets a default first so no path leaves a latch.
    always_comb begin
        hid   = to_hid(ext, shift);
        next0 = keycode[7:0];
        next1 = keycode[15:8];
        if (byte_valid && shift != 8'hE0 && shift != 8'hF0 && hid != 8'h00) begin
            if (brk) begin
                if (keycode[7:0]  == hid) next0 = 8'h00;
                if (keycode[15:8] == hid) next1 = 8'h00;
            end else if (keycode[7:0] != hid && keycode[15:8] != hid) begin
                if (keycode[7:0] == 8'h00)       next0 = hid;
                else if (keycode[15:8] == 8'h00) next1 = hid;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            keycode   <= '0;
            key_event <= 1'b0;
            ext       <= 1'b0;
            brk       <= 1'b0;
        end else begin
            keycode   <= {next1, next0};
            key_event <= ({next1, next0} != keycode);
            if (byte_valid) begin
                if (shift == 8'hE0) begin
                    ext <= 1'b1;
                end else if (shift == 8'hF0) begin
                    brk <= 1'b1;
                end else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Directed bench for ps2_keycode_rx: bit-bangs PS/2 frames and checks keycode,
// key_event and frame_err pulse counts against hand-computed values.
module tb_ps2_keycode_rx;
    localparam int TO   = 300;
    localparam int HALF = 10;

    logic        Clk;
    logic        Reset;
    logic        PS2_CLK;
    logic        PS2_DAT;
    logic [15:0] keycode;
    logic        key_event;
    logic        frame_err;

    int errors = 0;
    int checks = 0;
    int ev_cnt = 0;
    int fe_cnt = 0;
    int ev_mark;
    int fe_mark;

    ps2_keycode_rx #(.TIMEOUT_CYCLES(TO)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .PS2_CLK   (PS2_CLK),
        .PS2_DAT   (PS2_DAT),
        .keycode   (keycode),
        .key_event (key_event),
        .frame_err (frame_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (key_event === 1'b1) ev_cnt++;
        if (frame_err === 1'b1) fe_cnt++;
    end

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic mark();
        ev_mark = ev_cnt;
        fe_mark = fe_cnt;
    endtask

    task automatic check_pulses(input string tag, input int ev_exp, input int fe_exp);
        check({tag, "_events"}, 16'(ev_cnt - ev_mark), 16'(ev_exp));
        check({tag, "_ferr"},   16'(fe_cnt - fe_mark), 16'(fe_exp));
    endtask

    task automatic ps2_bit(input logic b);
        PS2_DAT = b;
        repeat (HALF) @(negedge Clk);
        PS2_CLK = 1'b0;
        repeat (HALF) @(negedge Clk);
        PS2_CLK = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_bit);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ par_flip);
        ps2_bit(stop_bit);
        PS2_DAT = 1'b1;
        repeat (HALF) @(negedge Clk);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b1);
    endtask

    initial begin
        logic [7:0] b;
        Reset   = 1'b1;
        PS2_CLK = 1'b1;
        PS2_DAT = 1'b1;
        repeat (5) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check("reset_keycode", keycode, 16'h0000);
        check("reset_key_event", {15'd0, key_event}, 16'd0);
        check("reset_frame_err", {15'd0, frame_err}, 16'd0);

        mark();
        repeat (200) @(negedge Clk);
        check("idle_keycode", keycode, 16'h0000);
        check_pulses("idle", 0, 0);

        mark();
        send(8'h5A);
        check("enter_make", keycode, 16'h0028);
        check_pulses("enter_make", 1, 0);

        mark();
        send(8'hF0); send(8'h5A);
        check("enter_break", keycode, 16'h0000);
        check_pulses("enter_break", 1, 0);

        send(8'h1D);
        check("w_make", keycode, 16'h001A);
        send(8'hE0); send(8'h75);
        check("up_make", keycode, 16'h521A);
        mark();
        send(8'hF0); send(8'h1D);
        check("w_break_slot1_kept", keycode, 16'h5200);
        check_pulses("w_break", 1, 0);
        send(8'hE0); send(8'hF0); send(8'h75);
        check("up_break", keycode, 16'h0000);

        send(8'h1D); send(8'h1C);
        check("wa_held", keycode, 16'h041A);
        mark();
        send(8'h23);
        check("table_full_drop", keycode, 16'h041A);
        check_pulses("table_full", 0, 0);
        send(8'hF0); send(8'h1D); send(8'hF0); send(8'h1C);
        check("wa_released", keycode, 16'h0000);

        mark();
        send(8'h5A); send(8'h5A); send(8'h5A);
        check("typematic", keycode, 16'h0028);
        check_pulses("typematic", 1, 0);
        send(8'hF0); send(8'h5A);

        mark();
        send_frame(8'h5A, 1'b1, 1'b1);
        check("bad_parity", keycode, 16'h0000);
        check_pulses("bad_parity", 0, 1);

        mark();
        send_frame(8'h5A, 1'b0, 1'b0);
        check("bad_stop", keycode, 16'h0000);
        check_pulses("bad_stop", 0, 1);

        // Start bit plus three data bits, then the line goes quiet.
        mark();
        b = 8'h76;
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(b[i]);
        PS2_DAT = 1'b1;
        repeat (TO + 20) @(negedge Clk);
        check_pulses("timeout", 0, 1);
        mark();
        send(8'h76);
        check("after_timeout", keycode, 16'h0029);
        check_pulses("after_timeout", 1, 0);
        send(8'hF0); send(8'h76);
        check("esc_break", keycode, 16'h0000);

        send(8'h5A);
        check("enter_held", keycode, 16'h0028);
        b = 8'h5A;
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(b[i]);
        PS2_DAT = b[5];
        repeat (HALF) @(negedge Clk);
        PS2_CLK = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        check("midframe_reset", keycode, 16'h0000);
        PS2_CLK = 1'b1;
        PS2_DAT = 1'b1;
        repeat (5) @(negedge Clk);
        Reset = 1'b0;
        repeat (5) @(negedge Clk);
        mark();
        send(8'h29);
        check("space_after_reset", keycode, 16'h002C);
        check_pulses("space_after_reset", 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
